// File: rtl/router_ingress_buffer.sv
// router_ingress_buffer: per-port ingress FIFO that decodes and holds the XY route of each packet
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   s_tdata/s_tvalid/    upstream AXI-Stream slave; s_tready is low while full or in reset
//   s_tready/s_tlast
//   m_tdata/m_tvalid/    downstream AXI-Stream master towards the XY routing stage
//   m_tready/m_tlast
//   target_x/target_y    destination of the packet being forwarded, held for the whole packet
//   fifo_count           beats currently stored
//   busy                 high while a packet is being forwarded
module router_ingress_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    localparam int X_W          = $clog2(MAX_ROUTERS_X),
    localparam int Y_W          = $clog2(MAX_ROUTERS_Y),
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [X_W-1:0]        target_x,
    output logic [Y_W-1:0]        target_y,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, FWD} state_t;

    state_t              r_state;
    logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [CNT_W-1:0]    r_count;
    logic [X_W-1:0]      r_tx;
    logic [Y_W-1:0]      r_ty;
    logic [DATA_WIDTH:0] w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    assign w_head     = r_mem[r_rd];
    assign w_empty    = r_count == '0;
    // Full is taken from the registered count only, so a same-cycle pop never opens a slot early.
    assign w_full     = r_count == CNT_W'(FIFO_DEPTH);
    assign s_tready   = !rst && !w_full;
    assign m_tvalid   = (r_state == FWD) && !w_empty;
    assign w_push     = s_tvalid && s_tready;
    assign w_pop      = m_tvalid && m_tready;
    assign m_tdata    = w_head[DATA_WIDTH-1:0];
    assign m_tlast    = w_head[DATA_WIDTH];
    assign target_x   = r_tx;
    assign target_y   = r_ty;
    assign fifo_count = r_count;
    assign busy       = r_state == FWD;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {s_tlast, s_tdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // The route is captured only in IDLE from the header at the head, so it cannot move mid-packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_ty    <= '0;
        end else if (r_state == IDLE) begin
            if (!w_empty) begin
                r_tx    <= w_head[X_W-1:0];
                r_ty    <= w_head[X_W+Y_W-1:X_W];
                r_state <= FWD;
            end
        end else if (w_pop && m_tlast) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_router_ingress_buffer.sv
// tb_router_ingress_buffer: table vectors, directed corner sequences and random traffic against a queue model
module tb_router_ingress_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [1:0]    target_x;
    logic [1:0]    target_y;
    logic [3:0]    fifo_count;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of stored {last, data} beats, a forwarding flag and the held route.
    logic [DW:0]   q[$];
    bit            m_busy = 1'b0;
    int            m_tx = 0;
    int            m_ty = 0;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          r;
        bit          e_rdy;
        bit          e_mv;
        logic [31:0] e_d;
        bit          e_l;
        int          e_x;
        int          e_y;
        int          e_cnt;
        bit          e_busy;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    router_ingress_buffer dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .target_x(target_x), .target_y(target_y), .fifo_count(fifo_count), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit mv;
        mv = m_busy && q.size() > 0;
        chk("s_tready", s_tready, !rst && q.size() < DEPTH);
        chk("m_tvalid", m_tvalid, mv);
        if (mv) begin
            chk("m_tdata", m_tdata, q[0][DW-1:0]);
            chk("m_tlast", m_tlast, q[0][DW]);
        end
        chk("target_x", target_x, m_tx);
        chk("target_y", target_y, m_ty);
        chk("fifo_count", fifo_count, q.size());
        chk("busy", busy, m_busy);
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit l, input bit r);
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        #1;
        model_check();
    endtask

    task automatic advance();
        bit push;
        bit pop;
        int hd;
        push = !rst && s_tvalid && q.size() < DEPTH;
        pop  = !rst && m_busy && q.size() > 0 && m_tready;
        if (rst) begin
            q.delete();
            m_busy = 1'b0;
            m_tx = 0;
            m_ty = 0;
        end else begin
            if (!m_busy) begin
                if (q.size() > 0) begin
                    hd = int'(q[0][15:0]);
                    m_tx = hd % 4;
                    m_ty = (hd / 4) % 4;
                    m_busy = 1'b1;
                end
            end else if (pop && q[0][DW]) begin
                m_busy = 1'b0;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back({s_tlast, s_tdata});
        end
        @(posedge clk);
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit r);
        drive(v, d, l, r);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int  left;
        bit  pend;
        bit  acc;
        logic [31:0] cd;
        bit  cl;

        tbl[0] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 0, 1'b0};
        tbl[1] = '{1'b1, 32'h9,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 0, 1'b0};
        tbl[2] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1, 1'b0};
        tbl[3] = '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h9,  1'b0, 1, 2, 2, 1'b1};
        tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1, 2, 2, 1'b1};
        tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1, 2, 1, 1'b1};
        tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1, 2, 0, 1'b0};

        // Reset state while rst is held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_target", {target_x, target_y}, 0);
        rst = 1'b0;
        @(posedge clk);

        // 3-beat packet, header x=1 y=2
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("tbl%0d_s_tready", i), s_tready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_m_tvalid", i), m_tvalid, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_m_tdata", i), m_tdata, tbl[i].e_d);
                chk($sformatf("tbl%0d_m_tlast", i), m_tlast, tbl[i].e_l);
            end
            chk($sformatf("tbl%0d_target_x", i), target_x, tbl[i].e_x);
            chk($sformatf("tbl%0d_target_y", i), target_y, tbl[i].e_y);
            chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            advance();
        end

        // Back-pressure: fill 8 beats, 9th refused, then drain in order
        for (int i = 0; i < 8; i++)
            cyc(1'b1, (i == 0) ? 32'hE : 32'h200 + i, i == 7, 1'b0);
        drive(1'b1, 32'h5, 1'b1, 1'b0);
        chk("bp_count_full", fifo_count, 8);
        chk("bp_s_tready_low", s_tready, 0);
        chk("bp_target_x", target_x, 2);
        chk("bp_target_y", target_y, 3);
        advance();
        chk("bp_ninth_refused", fifo_count, 8);
        idle(12);

        // Back-to-back packets x=3,y=0 then x=0,y=3
        cyc(1'b1, 32'h3, 1'b0, 1'b1);
        cyc(1'b1, 32'h31, 1'b1, 1'b1);
        cyc(1'b1, 32'hC, 1'b0, 1'b1);
        cyc(1'b1, 32'hC1, 1'b1, 1'b1);
        idle(6);
        chk("b2b_target_x", target_x, 0);
        chk("b2b_target_y", target_y, 3);

        // Single-beat packet x=2,y=1
        cyc(1'b1, 32'h6, 1'b1, 1'b1);
        idle(4);
        chk("single_target_x", target_x, 2);
        chk("single_target_y", target_y, 1);
        chk("single_busy_end", busy, 0);

        // Async reset after 2 of 4 beats drained
        cyc(1'b1, 32'h5, 1'b0, 1'b1);
        cyc(1'b1, 32'h51, 1'b0, 1'b1);
        cyc(1'b1, 32'h52, 1'b0, 1'b1);
        cyc(1'b1, 32'h53, 1'b1, 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_m_tvalid", m_tvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_s_tready", s_tready, 0);
        chk("arst_target", {target_x, target_y}, 0);
        q.delete();
        m_busy = 1'b0;
        m_tx = 0;
        m_ty = 0;
        @(posedge clk);
        cyc(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 32'hB, 1'b1, 1'b1);
        idle(3);
        chk("post_rst_target_x", target_x, 3);
        chk("post_rst_target_y", target_y, 2);

        // Random traffic, packets of 1..4 beats
        left = 0;
        pend = 1'b0;
        cd = '0;
        cl = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                if (left == 0) left = $urandom_range(1, 4);
                cd = $urandom;
                left--;
                cl = left == 0;
                pend = 1'b1;
            end
            drive(pend, pend ? cd : 32'h0, pend && cl, $urandom_range(0, 9) < 7);
            acc = pend && q.size() < DEPTH;
            advance();
            if (acc) pend = 1'b0;
        end
        while (pend) begin
            drive(1'b1, cd, cl, 1'b1);
            acc = q.size() < DEPTH;
            advance();
            if (acc) pend = 1'b0;
        end
        idle(2 * DEPTH + 4);
        chk("final_drained", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/router_ingress_buffer.md
Name: router_ingress_buffer

Overview:
- Per-port ingress stage of the mesh router, directly upstream of the XY routing/demux stage.
- Buffers incoming AXI-Stream beats in a FIFO and decodes the destination coordinates from the header (first) beat of each packet.
- Holds target_x/target_y stable for the whole packet and presents the buffered beats to the routing stage.
- Guarantees that the route decision cannot change mid-packet.

Parameters:
- DATA_WIDTH, 32, width of tdata.
- FIFO_DEPTH, 8, buffer depth in beats; power of two, minimum 2.
- MAX_ROUTERS_X, 4, mesh size in X; X_W = $clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh size in Y; Y_W = $clog2(MAX_ROUTERS_Y).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_tdata  in  DATA_WIDTH  upstream beat data.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  buffer can accept a beat.
- s_tlast  in  1  last beat of packet.
- m_tdata  out  DATA_WIDTH  beat data to routing stage.
- m_tvalid  out  1  beat valid to routing stage.
- m_tready  in  1  routing stage accepts the beat.
- m_tlast  out  1  last beat of packet.
- target_x  out  X_W  latched destination X for current packet.
- target_y  out  Y_W  latched destination Y for current packet.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  beats currently stored.
- busy  out  1  a packet is being forwarded (state FWD).

Behaviour:
- Reset (rst high, asynchronous):
  - FIFO empty, rd/wr pointers 0, fifo_count 0.
  - state IDLE; target_x/target_y 0; m_tvalid 0; busy 0; s_tready 0 while rst is high.
- FIFO:
  - Storage is {tlast, tdata}.
  - Push on s_tvalid && s_tready.
  - s_tready = !full, derived from the registered count. When full, s_tready stays 0 even if a pop happens in the same cycle.
  - Pop on m_tvalid && m_tready.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A beat written at edge N is at the head from cycle N+1.
- Header format: the first beat of every packet is the header.
  - tdata[X_W-1:0] holds the destination X.
  - tdata[X_W+Y_W-1:X_W] holds the destination Y.
  - The header beat is forwarded like every other beat; it is not stripped.
- State machine:
  - IDLE: m_tvalid = 0. If the FIFO is non-empty, latch target_x/target_y from the head beat and go to FWD on the next edge.
  - FWD: m_tvalid = !empty; m_tdata/m_tlast come from the head. target_x/target_y hold their latched values. On a pop with m_tlast = 1, go to IDLE.
- Latency:
  - Header beat pushed at edge N: latched at edge N+1, m_tvalid high in cycle N+2.
  - Body beats: one cycle from push to head.
  - One bubble cycle between consecutive packets (the IDLE cycle).
- Stability: target_x/target_y change only in IDLE. They are constant from the first to the last beat of a packet, including cycles where m_tready = 0.
- Back-pressure: with m_tvalid high and m_tready low, m_tdata, m_tlast and the head beat remain unchanged (AXI-Stream rule).
- Single-beat packet: header with tlast = 1 pops in FWD, then the state returns to IDLE.
- FIFO empty mid-packet in FWD: m_tvalid drops to 0 and the state stays FWD; target is still held.
- Reset mid-packet: all stored beats are discarded and the state returns to IDLE. Upstream must restart packets after reset.
- busy = (state == FWD).

Test Plan:
- Reset then idle: rst pulse -> s_tready=1 after release, m_tvalid=0, fifo_count=0, target_x=0, target_y=0.
- 3-beat packet, header 0x0000_0009 (x=1, y=2), m_tready=1 -> target_x=1, target_y=2 latched; m_tvalid first high 2 cycles after the header push; beats out in order; m_tlast on the 3rd beat; state returns to IDLE.
- Back-pressure: m_tready=0 while pushing 8 beats -> fifo_count=8, s_tready=0, 9th beat not accepted; target unchanged. Release m_tready -> all 8 beats drain in order.
- Two back-to-back packets, headers x=3,y=0 then x=0,y=3 -> target switches only after the first packet's tlast pop, with exactly one m_tvalid=0 cycle between them.
- Single-beat packet (tlast=1 on header, x=2, y=1) -> one beat out with m_tlast=1; target 2/1; busy pulses for the forwarding cycles only.
- Async reset asserted mid-packet (2 of 4 beats drained) -> outputs return to reset values immediately; the next header after release is latched correctly.
